// File: rtl/vx_csr_rmw_stage.sv
// CSR read-modify-write issue stage: single-cycle RMW against the CSR data block,
// with the old value returned to writeback through a small response FIFO.
module vx_csr_rmw_stage #(
  parameter int          NUM_WARPS       = 4,
  parameter int          UUID_BITS       = 44,
  parameter int          RSP_DEPTH       = 2,
  parameter logic [11:0] CSR_FFLAGS_ADDR = 12'h001,
  parameter logic [11:0] CSR_FRM_ADDR    = 12'h002,
  parameter logic [11:0] CSR_FCSR_ADDR   = 12'h003,
  parameter int          NW_BITS         = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [UUID_BITS-1:0] req_uuid,
  input  logic [NW_BITS-1:0]   req_wid,
  input  logic [4:0]           req_rd,
  input  logic                 req_wb,
  input  logic [1:0]           req_op,
  input  logic                 req_use_imm,
  input  logic [4:0]           req_imm,
  input  logic [31:0]          req_rs1,
  input  logic [11:0]          req_addr,
  input  logic [NUM_WARPS-1:0] fpu_pending,
  output logic                 read_enable,
  output logic [UUID_BITS-1:0] read_uuid,
  output logic [11:0]          read_addr,
  output logic [NW_BITS-1:0]   read_wid,
  input  logic [31:0]          read_data,
  output logic                 write_enable,
  output logic [UUID_BITS-1:0] write_uuid,
  output logic [11:0]          write_addr,
  output logic [NW_BITS-1:0]   write_wid,
  output logic [31:0]          write_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [UUID_BITS-1:0] rsp_uuid,
  output logic [NW_BITS-1:0]   rsp_wid,
  output logic [4:0]           rsp_rd,
  output logic                 rsp_wb,
  output logic [31:0]          rsp_data,
  output logic                 busy,
  output logic [31:0]          stall_cycles
);

  localparam int PTR_BITS = $clog2(RSP_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam int ENTRY_W  = UUID_BITS + NW_BITS + 5 + 1 + 32;

  logic [ENTRY_W-1:0]  fifo_mem [RSP_DEPTH];
  logic [PTR_BITS-1:0] wr_ptr, rd_ptr;
  logic [CNT_BITS-1:0] count;

  logic [31:0] src, new_val;
  logic        fp_csr, hazard, full, fire, pop, wr_ok;

  assign src    = req_use_imm ? {27'b0, req_imm} : req_rs1;
  assign fp_csr = (req_addr == CSR_FFLAGS_ADDR) || (req_addr == CSR_FRM_ADDR) ||
                  (req_addr == CSR_FCSR_ADDR);
  assign hazard = fp_csr & fpu_pending[req_wid];
  assign full   = (count == CNT_BITS'(RSP_DEPTH));

  // Gated by reset so nothing is accepted or strobed while reset is held low.
  assign req_ready = reset & ~full & ~hazard;
  assign fire      = req_valid & req_ready;

  // Opcode 0 falls into the set path with the write suppressed.
  always_comb begin
    new_val = read_data | src;
    wr_ok   = (src != 32'd0) && (req_op != 2'd0);
    case (req_op)
      2'd1: begin
        new_val = src;
        wr_ok   = 1'b1;
      end
      2'd3: new_val = read_data & ~src;
      default: ;
    endcase
  end

  assign read_enable  = fire;
  assign read_uuid    = req_uuid;
  assign read_addr    = req_addr;
  assign read_wid     = req_wid;
  assign write_enable = fire & wr_ok;
  assign write_uuid   = req_uuid;
  assign write_addr   = req_addr;
  assign write_wid    = req_wid;
  assign write_data   = new_val;

  assign rsp_valid = reset & (count != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign {rsp_uuid, rsp_wid, rsp_rd, rsp_wb, rsp_data} = fifo_mem[rd_ptr];
  assign busy      = req_valid | rsp_valid;

  always_ff @(posedge clk) begin
    if (fire)
      fifo_mem[wr_ptr] <= {req_uuid, req_wid, req_rd, req_wb, read_data};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      stall_cycles <= '0;
    end else begin
      if (fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (fire && !pop)      count <= count + 1'b1;
      else if (!fire && pop) count <= count - 1'b1;
      if (req_valid && hazard && !full) stall_cycles <= stall_cycles + 32'd1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && fire)
      assert (req_op != 2'd0) else $error("illegal CSR op 0 accepted, uuid %0h", req_uuid);
  end
`endif

endmodule

// File: tb/tb_vx_csr_rmw_stage.sv
// Directed bench for vx_csr_rmw_stage with a behavioural CSR data block
// (combinational read, registered write).
module tb_vx_csr_rmw_stage;
  localparam int NW = 2;
  localparam int UB = 44;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_wb, req_use_imm;
  logic [UB-1:0] req_uuid;
  logic [NW-1:0] req_wid;
  logic [4:0]    req_rd, req_imm;
  logic [1:0]    req_op;
  logic [31:0]   req_rs1;
  logic [11:0]   req_addr;
  logic [3:0]    fpu_pending;
  logic          read_enable, write_enable, rsp_valid, rsp_ready, rsp_wb, busy;
  logic [UB-1:0] read_uuid, write_uuid, rsp_uuid;
  logic [11:0]   read_addr, write_addr;
  logic [NW-1:0] read_wid, write_wid, rsp_wid;
  logic [31:0]   read_data, write_data, rsp_data, stall_cycles;
  logic [4:0]    rsp_rd;

  logic [31:0] csr_mem [4096];
  logic        poke_en = 1'b0;
  logic [11:0] poke_addr = '0;
  logic [31:0] poke_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (poke_en)           csr_mem[poke_addr] <= poke_data;
    else if (write_enable) csr_mem[write_addr] <= write_data;
  end
  assign read_data = csr_mem[read_addr];

  vx_csr_rmw_stage dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_uuid(req_uuid), .req_wid(req_wid),
    .req_rd(req_rd), .req_wb(req_wb), .req_op(req_op), .req_use_imm(req_use_imm),
    .req_imm(req_imm), .req_rs1(req_rs1), .req_addr(req_addr), .fpu_pending(fpu_pending),
    .read_enable(read_enable), .read_uuid(read_uuid), .read_addr(read_addr),
    .read_wid(read_wid), .read_data(read_data),
    .write_enable(write_enable), .write_uuid(write_uuid), .write_addr(write_addr),
    .write_wid(write_wid), .write_data(write_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_uuid(rsp_uuid), .rsp_wid(rsp_wid),
    .rsp_rd(rsp_rd), .rsp_wb(rsp_wb), .rsp_data(rsp_data),
    .busy(busy), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic drive(input logic [1:0] op, input logic imm_sel, input logic [4:0] imm,
                       input logic [31:0] rs1, input logic [11:0] a, input logic [NW-1:0] w,
                       input logic [UB-1:0] u);
    req_valid = 1'b1; req_op = op; req_use_imm = imm_sel; req_imm = imm; req_rs1 = rs1;
    req_addr = a; req_wid = w; req_uuid = u; req_rd = u[4:0]; req_wb = 1'b1;
  endtask

  // One accepted request: checks the same-cycle write, then the head response.
  task automatic issue(input string tag, input logic [1:0] op, input logic imm_sel,
                       input logic [4:0] imm, input logic [31:0] rs1, input logic [11:0] a,
                       input logic [UB-1:0] u, input logic exp_we, input logic [31:0] exp_wd,
                       input logic [31:0] exp_rsp);
    @(negedge clk);
    drive(op, imm_sel, imm, rs1, a, '0, u);
    #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_we"}, 64'(write_enable), 64'(exp_we));
    if (exp_we) chk({tag, "_wdata"}, 64'(write_data), 64'(exp_wd));
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(exp_rsp));
  endtask

  initial begin
    reset = 1'b0; rsp_ready = 1'b1; fpu_pending = '0;
    drive(2'd1, 1'b0, 5'd0, 32'h1, 12'h340, '0, 44'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_read_en", 64'(read_enable), 64'd0);
    chk("rst_write_en", 64'(write_enable), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_stall", 64'(stall_cycles), 64'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("idle_busy", 64'(busy), 64'd0);

    // RW with register source
    poke(12'h340, 32'hAA);
    issue("rw_reg", 2'd1, 1'b0, 5'd0, 32'h1234, 12'h340, 44'h3, 1'b1, 32'h1234, 32'hAA);
    chk("rw_rsp_uuid", 64'(rsp_uuid), 64'h3);
    chk("rw_rsp_rd", 64'(rsp_rd), 64'd3);
    chk("rw_rsp_wb", 64'(rsp_wb), 64'd1);
    chk("rw_rsp_wid", 64'(rsp_wid), 64'd0);

    // Set / clear with immediates
    poke(12'h300, 32'hF0);
    issue("rs_imm", 2'd2, 1'b1, 5'h0F, 32'hFFFF_FFFF, 12'h300, 44'h4, 1'b1, 32'hFF, 32'hF0);
    issue("rc_imm", 2'd3, 1'b1, 5'h03, 32'hFFFF_FFFF, 12'h300, 44'h5, 1'b1, 32'hFC, 32'hFF);
    issue("rs_zero", 2'd2, 1'b1, 5'h00, 32'hFFFF_FFFF, 12'h300, 44'h6, 1'b0, 32'h0, 32'hFC);
    @(posedge clk); #1;
    chk("rs_zero_kept", 64'(csr_mem[12'h300]), 64'hFC);

    // FPU hazard on warp 2
    poke(12'h001, 32'h0);
    @(negedge clk);
    fpu_pending = 4'b0100;
    drive(2'd1, 1'b0, 5'd0, 32'h1F, 12'h001, 2'd2, 44'h7);
    #1;
    chk("haz_ready", 64'(req_ready), 64'd0);
    chk("haz_read_en", 64'(read_enable), 64'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("haz_stall5", 64'(stall_cycles), 64'd5);
    chk("haz_still_blocked", 64'(req_ready), 64'd0);
    fpu_pending = 4'b0000;
    #1;
    chk("haz_clear_ready", 64'(req_ready), 64'd1);
    chk("haz_clear_wdata", 64'(write_data), 64'h1F);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("haz_rsp_data", 64'(rsp_data), 64'h0);
    chk("haz_rsp_wid", 64'(rsp_wid), 64'd2);
    @(negedge clk);
    fpu_pending = 4'b0100;
    drive(2'd2, 1'b1, 5'h01, 32'h0, 12'h001, 2'd1, 44'h8);
    #1;
    chk("other_warp_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("other_warp_rsp", 64'(rsp_data), 64'h1F);
    chk("stall_hold", 64'(stall_cycles), 64'd5);
    fpu_pending = 4'b0000;

    // Backpressure with a 2-deep FIFO
    poke(12'h350, 32'h10);
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(2'd1, 1'b0, 5'd0, 32'h11, 12'h350, '0, 44'd10);
    #1; chk("bp_a_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    drive(2'd1, 1'b0, 5'd0, 32'h12, 12'h350, '0, 44'd11);
    #1; chk("bp_b_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    drive(2'd1, 1'b0, 5'd0, 32'h13, 12'h350, '0, 44'd12);
    #1; chk("bp_c_blocked", 64'(req_ready), 64'd0);
    chk("bp_head_uuid", 64'(rsp_uuid), 64'd10);
    chk("bp_head_data", 64'(rsp_data), 64'h10);
    @(negedge clk);
    chk("bp_c_still_blocked", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    #1; chk("bp_ready_indep", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    chk("bp_b_uuid", 64'(rsp_uuid), 64'd11);
    chk("bp_b_data", 64'(rsp_data), 64'h11);
    @(negedge clk);
    chk("bp_c_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_c_uuid", 64'(rsp_uuid), 64'd12);
    chk("bp_c_data", 64'(rsp_data), 64'h12);
    @(posedge clk); #1;
    chk("bp_drained", 64'(rsp_valid), 64'd0);
    chk("bp_final_csr", 64'(csr_mem[12'h350]), 64'h13);

    // Same CSR on consecutive cycles
    poke(12'h360, 32'h0);
    @(negedge clk);
    drive(2'd1, 1'b0, 5'd0, 32'h5, 12'h360, '0, 44'd20);
    #1; chk("b2b_first_wdata", 64'(write_data), 64'h5);
    @(negedge clk);
    drive(2'd2, 1'b0, 5'd0, 32'h2, 12'h360, '0, 44'd21);
    #1;
    chk("b2b_second_we", 64'(write_enable), 64'd1);
    chk("b2b_second_wdata", 64'(write_data), 64'h7);
    chk("b2b_first_rsp", 64'(rsp_data), 64'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_second_rsp", 64'(rsp_data), 64'h5);
    @(posedge clk); #1;

    // Reset with two responses queued
    poke(12'h370, 32'h40);
    @(negedge clk); rsp_ready = 1'b0;
    issue("rq_a", 2'd1, 1'b0, 5'd0, 32'h41, 12'h370, 44'd30, 1'b1, 32'h41, 32'h40);
    issue("rq_b", 2'd1, 1'b0, 5'd0, 32'h42, 12'h370, 44'd31, 1'b1, 32'h42, 32'h40);
    @(negedge clk);
    chk("rq_full", 64'(req_ready), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rq_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rq_rst_stall", 64'(stall_cycles), 64'd0);
    @(negedge clk);
    reset = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("rq_discarded", 64'(rsp_valid), 64'd0);
    issue("rq_after", 2'd1, 1'b0, 5'd0, 32'h43, 12'h370, 44'd32, 1'b1, 32'h43, 32'h42);
    chk("rq_after_uuid", 64'(rsp_uuid), 64'd32);
    @(posedge clk); #1;
    chk("end_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
